// File: rtl/axi_width_upsizer.sv
// axi_width_upsizer: AXI3 upsizer, NARROW_W slave port to WIDE_W master port.
// Ports: clk_i, rst_i; upstream ar/r/aw/w/b (NARROW_W); downstream ar/r/aw/w/b (WIDE_W).
module axi_width_upsizer #(
  parameter int NARROW_W = 32,
  parameter int WIDE_W   = 64,
  parameter int ID_W     = 4,
  parameter int ADDR_W   = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [ID_W-1:0]       arid_i,
  input  logic [ADDR_W-1:0]     araddr_i,
  input  logic [3:0]            arlen_i,
  input  logic [2:0]            arsize_i,
  input  logic [1:0]            arburst_i,
  input  logic                  arvalid_i,
  output logic                  arready_o,
  output logic [ID_W-1:0]       rid_o,
  output logic [NARROW_W-1:0]   rdata_o,
  output logic [1:0]            rresp_o,
  output logic                  rlast_o,
  output logic                  rvalid_o,
  input  logic                  rready_i,
  input  logic [ID_W-1:0]       awid_i,
  input  logic [ADDR_W-1:0]     awaddr_i,
  input  logic [3:0]            awlen_i,
  input  logic [2:0]            awsize_i,
  input  logic [1:0]            awburst_i,
  input  logic                  awvalid_i,
  output logic                  awready_o,
  input  logic [ID_W-1:0]       wid_i,
  input  logic [NARROW_W-1:0]   wdata_i,
  input  logic [NARROW_W/8-1:0] wstrb_i,
  input  logic                  wlast_i,
  input  logic                  wvalid_i,
  output logic                  wready_o,
  output logic [ID_W-1:0]       bid_o,
  output logic [1:0]            bresp_o,
  output logic                  bvalid_o,
  input  logic                  bready_i,
  output logic [ID_W-1:0]       arid_o,
  output logic [ADDR_W-1:0]     araddr_o,
  output logic [3:0]            arlen_o,
  output logic [2:0]            arsize_o,
  output logic [1:0]            arburst_o,
  output logic                  arvalid_o,
  input  logic                  arready_i,
  input  logic [ID_W-1:0]       rid_i,
  input  logic [WIDE_W-1:0]     rdata_i,
  input  logic [1:0]            rresp_i,
  input  logic                  rlast_i,
  input  logic                  rvalid_i,
  output logic                  rready_o,
  output logic [ID_W-1:0]       awid_o,
  output logic [ADDR_W-1:0]     awaddr_o,
  output logic [3:0]            awlen_o,
  output logic [2:0]            awsize_o,
  output logic [1:0]            awburst_o,
  output logic                  awvalid_o,
  input  logic                  awready_i,
  output logic [ID_W-1:0]       wid_o,
  output logic [WIDE_W-1:0]     wdata_o,
  output logic [WIDE_W/8-1:0]   wstrb_o,
  output logic                  wlast_o,
  output logic                  wvalid_o,
  input  logic                  wready_i,
  input  logic [ID_W-1:0]       bid_i,
  input  logic [1:0]            bresp_i,
  input  logic                  bvalid_i,
  output logic                  bready_o
);

  localparam int NB    = NARROW_W / 8;
  localparam int RATIO = WIDE_W / NARROW_W;
  localparam int PW    = $clog2(WIDE_W / 8);
  localparam int LW    = $clog2(NB);
  localparam logic [1:0] BURST_FIXED = 2'b00;

  typedef enum logic {RD_IDLE, RD_BUSY} rd_state_e;
  typedef enum logic [1:0] {WR_IDLE, WR_DATA, WR_RESP} wr_state_e;

  rd_state_e       rd_state_q, rd_state_d;
  wr_state_e       wr_state_q, wr_state_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [2:0]      rd_size_q, rd_size_d, wr_size_q, wr_size_d;
  logic [1:0]      rd_burst_q, rd_burst_d, wr_burst_q, wr_burst_d;
  logic [PW-LW-1:0] rd_lane, wr_lane;
  logic            ar_hs, r_hs, aw_hs, w_hs, b_hs;

  assign ar_hs = arvalid_i & arready_i & (rd_state_q == RD_IDLE);
  assign r_hs  = rvalid_i & rready_i;
  assign aw_hs = awvalid_i & awready_i & (wr_state_q == WR_IDLE);
  assign w_hs  = wvalid_i & wready_i & (wr_state_q == WR_DATA);
  assign b_hs  = bvalid_i & bready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_state_q <= RD_IDLE;
      wr_state_q <= WR_IDLE;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      rd_size_q  <= '0;
      wr_size_q  <= '0;
      rd_burst_q <= '0;
      wr_burst_q <= '0;
    end else begin
      rd_state_q <= rd_state_d;
      wr_state_q <= wr_state_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_size_q  <= rd_size_d;
      wr_size_q  <= wr_size_d;
      rd_burst_q <= rd_burst_d;
      wr_burst_q <= wr_burst_d;
    end
  end

  // Pointer step is 2^size; oversize steps simply wrap or vanish.
  always_comb begin
    rd_state_d = rd_state_q;
    rd_ptr_d   = rd_ptr_q;
    rd_size_d  = rd_size_q;
    rd_burst_d = rd_burst_q;
    unique case (rd_state_q)
      RD_IDLE: if (ar_hs) begin
        rd_state_d = RD_BUSY;
        rd_ptr_d   = araddr_i[PW-1:0];
        rd_size_d  = arsize_i;
        rd_burst_d = arburst_i;
      end
      RD_BUSY: if (r_hs) begin
        if (rd_burst_q != BURST_FIXED)
          rd_ptr_d = rd_ptr_q + (PW'(1) << rd_size_q);
        if (rlast_i)
          rd_state_d = RD_IDLE;
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  always_comb begin
    wr_state_d = wr_state_q;
    wr_ptr_d   = wr_ptr_q;
    wr_size_d  = wr_size_q;
    wr_burst_d = wr_burst_q;
    unique case (wr_state_q)
      WR_IDLE: if (aw_hs) begin
        wr_state_d = WR_DATA;
        wr_ptr_d   = awaddr_i[PW-1:0];
        wr_size_d  = awsize_i;
        wr_burst_d = awburst_i;
      end
      WR_DATA: if (w_hs) begin
        if (wr_burst_q != BURST_FIXED)
          wr_ptr_d = wr_ptr_q + (PW'(1) << wr_size_q);
        if (wlast_i)
          wr_state_d = WR_RESP;
      end
      WR_RESP: if (b_hs) wr_state_d = WR_IDLE;
      default: wr_state_d = WR_IDLE;
    endcase
  end

  assign rd_lane = rd_ptr_q[PW-1:LW];
  assign wr_lane = wr_ptr_q[PW-1:LW];

  always_comb begin
    arvalid_o = arvalid_i & (rd_state_q == RD_IDLE);
    arready_o = arready_i & (rd_state_q == RD_IDLE);
    rdata_o   = rdata_i[rd_lane*NARROW_W +: NARROW_W];
  end

  always_comb begin
    awvalid_o = awvalid_i & (wr_state_q == WR_IDLE);
    awready_o = awready_i & (wr_state_q == WR_IDLE);
    wvalid_o  = wvalid_i & (wr_state_q == WR_DATA);
    wready_o  = wready_i & (wr_state_q == WR_DATA);
    wstrb_o   = '0;
    wstrb_o[wr_lane*NB +: NB] = wstrb_i;
  end

  assign wdata_o   = {RATIO{wdata_i}};
  assign arid_o    = arid_i;
  assign araddr_o  = araddr_i;
  assign arlen_o   = arlen_i;
  assign arsize_o  = arsize_i;
  assign arburst_o = arburst_i;
  assign rid_o     = rid_i;
  assign rresp_o   = rresp_i;
  assign rlast_o   = rlast_i;
  assign rvalid_o  = rvalid_i;
  assign rready_o  = rready_i;
  assign awid_o    = awid_i;
  assign awaddr_o  = awaddr_i;
  assign awlen_o   = awlen_i;
  assign awsize_o  = awsize_i;
  assign awburst_o = awburst_i;
  assign wid_o     = wid_i;
  assign wlast_o   = wlast_i;
  assign bid_o     = bid_i;
  assign bresp_o   = bresp_i;
  assign bvalid_o  = bvalid_i;
  assign bready_o  = bready_i;

endmodule

// File: tb/tb_axi_width_upsizer.sv
// tb_axi_width_upsizer: 32->64 and 32->128 upsizers driven by shared stimulus.
// Ports: none; both DUT instances share all narrow-side and control inputs.
module tb_axi_width_upsizer;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [3:0]  arid_i, awid_i, wid_i, rid_i, bid_i;
  logic [31:0] araddr_i, awaddr_i;
  logic [3:0]  arlen_i, awlen_i;
  logic [2:0]  arsize_i, awsize_i;
  logic [1:0]  arburst_i, awburst_i, rresp_i, bresp_i;
  logic arvalid_i, arready_i, rlast_i, rvalid_i, rready_i;
  logic awvalid_i, awready_i, wlast_i, wvalid_i, wready_i;
  logic bvalid_i, bready_i;
  logic [63:0]  rdata_i;
  logic [127:0] xrdata_i;
  logic [31:0]  wdata_i;
  logic [3:0]   wstrb_i;

  logic arready_o, rlast_o, rvalid_o, awready_o, wready_o, bvalid_o;
  logic arvalid_o, rready_o, awvalid_o, wlast_o, wvalid_o, bready_o;
  logic [3:0]  rid_o, bid_o, arid_o, awid_o, wid_o, arlen_o, awlen_o;
  logic [31:0] rdata_o, araddr_o, awaddr_o;
  logic [1:0]  rresp_o, bresp_o, arburst_o, awburst_o;
  logic [2:0]  arsize_o, awsize_o;
  logic [63:0] wdata_o;
  logic [7:0]  wstrb_o;

  logic x_arready_o, x_rlast_o, x_rvalid_o, x_awready_o, x_wready_o;
  logic x_bvalid_o, x_arvalid_o, x_rready_o, x_awvalid_o, x_wlast_o;
  logic x_wvalid_o, x_bready_o;
  logic [3:0]   x_rid_o, x_bid_o, x_arid_o, x_awid_o, x_wid_o;
  logic [3:0]   x_arlen_o, x_awlen_o;
  logic [31:0]  x_rdata_o, x_araddr_o, x_awaddr_o;
  logic [1:0]   x_rresp_o, x_bresp_o, x_arburst_o, x_awburst_o;
  logic [2:0]   x_arsize_o, x_awsize_o;
  logic [127:0] x_wdata_o;
  logic [15:0]  x_wstrb_o;

  logic [31:0] rd_q[$];
  logic [71:0] wq[$];
  logic [15:0] xq[$];

  axi_width_upsizer #(.NARROW_W(32), .WIDE_W(64)) dut (
    .clk_i(clk), .rst_i(rst),
    .arid_i(arid_i), .araddr_i(araddr_i), .arlen_i(arlen_i),
    .arsize_i(arsize_i), .arburst_i(arburst_i),
    .arvalid_i(arvalid_i), .arready_o(arready_o),
    .rid_o(rid_o), .rdata_o(rdata_o), .rresp_o(rresp_o),
    .rlast_o(rlast_o), .rvalid_o(rvalid_o), .rready_i(rready_i),
    .awid_i(awid_i), .awaddr_i(awaddr_i), .awlen_i(awlen_i),
    .awsize_i(awsize_i), .awburst_i(awburst_i),
    .awvalid_i(awvalid_i), .awready_o(awready_o),
    .wid_i(wid_i), .wdata_i(wdata_i), .wstrb_i(wstrb_i),
    .wlast_i(wlast_i), .wvalid_i(wvalid_i), .wready_o(wready_o),
    .bid_o(bid_o), .bresp_o(bresp_o), .bvalid_o(bvalid_o),
    .bready_i(bready_i),
    .arid_o(arid_o), .araddr_o(araddr_o), .arlen_o(arlen_o),
    .arsize_o(arsize_o), .arburst_o(arburst_o),
    .arvalid_o(arvalid_o), .arready_i(arready_i),
    .rid_i(rid_i), .rdata_i(rdata_i), .rresp_i(rresp_i),
    .rlast_i(rlast_i), .rvalid_i(rvalid_i), .rready_o(rready_o),
    .awid_o(awid_o), .awaddr_o(awaddr_o), .awlen_o(awlen_o),
    .awsize_o(awsize_o), .awburst_o(awburst_o),
    .awvalid_o(awvalid_o), .awready_i(awready_i),
    .wid_o(wid_o), .wdata_o(wdata_o), .wstrb_o(wstrb_o),
    .wlast_o(wlast_o), .wvalid_o(wvalid_o), .wready_i(wready_i),
    .bid_i(bid_i), .bresp_i(bresp_i), .bvalid_i(bvalid_i),
    .bready_o(bready_o)
  );

  axi_width_upsizer #(.NARROW_W(32), .WIDE_W(128)) dut128 (
    .clk_i(clk), .rst_i(rst),
    .arid_i(arid_i), .araddr_i(araddr_i), .arlen_i(arlen_i),
    .arsize_i(arsize_i), .arburst_i(arburst_i),
    .arvalid_i(arvalid_i), .arready_o(x_arready_o),
    .rid_o(x_rid_o), .rdata_o(x_rdata_o), .rresp_o(x_rresp_o),
    .rlast_o(x_rlast_o), .rvalid_o(x_rvalid_o), .rready_i(rready_i),
    .awid_i(awid_i), .awaddr_i(awaddr_i), .awlen_i(awlen_i),
    .awsize_i(awsize_i), .awburst_i(awburst_i),
    .awvalid_i(awvalid_i), .awready_o(x_awready_o),
    .wid_i(wid_i), .wdata_i(wdata_i), .wstrb_i(wstrb_i),
    .wlast_i(wlast_i), .wvalid_i(wvalid_i), .wready_o(x_wready_o),
    .bid_o(x_bid_o), .bresp_o(x_bresp_o), .bvalid_o(x_bvalid_o),
    .bready_i(bready_i),
    .arid_o(x_arid_o), .araddr_o(x_araddr_o), .arlen_o(x_arlen_o),
    .arsize_o(x_arsize_o), .arburst_o(x_arburst_o),
    .arvalid_o(x_arvalid_o), .arready_i(arready_i),
    .rid_i(rid_i), .rdata_i(xrdata_i), .rresp_i(rresp_i),
    .rlast_i(rlast_i), .rvalid_i(rvalid_i), .rready_o(x_rready_o),
    .awid_o(x_awid_o), .awaddr_o(x_awaddr_o), .awlen_o(x_awlen_o),
    .awsize_o(x_awsize_o), .awburst_o(x_awburst_o),
    .awvalid_o(x_awvalid_o), .awready_i(awready_i),
    .wid_o(x_wid_o), .wdata_o(x_wdata_o), .wstrb_o(x_wstrb_o),
    .wlast_o(x_wlast_o), .wvalid_o(x_wvalid_o), .wready_i(wready_i),
    .bid_i(bid_i), .bresp_i(bresp_i), .bvalid_i(bvalid_i),
    .bready_o(x_bready_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    arvalid_i = 0; arready_i = 0; rvalid_i = 0; rready_i = 0;
    rlast_i = 0; awvalid_i = 0; awready_i = 0; wvalid_i = 0;
    wready_i = 0; wlast_i = 0; bvalid_i = 0; bready_i = 0;
  endtask

  task automatic do_ar(input logic [31:0] a, input logic [3:0] l,
                       input logic [2:0] s, input logic [1:0] b);
    araddr_i = a; arlen_i = l; arsize_i = s; arburst_i = b;
    arvalid_i = 1; arready_i = 1;
    tick();
    arvalid_i = 0; arready_i = 0;
  endtask

  task automatic do_aw(input logic [31:0] a, input logic [3:0] l,
                       input logic [2:0] s, input logic [1:0] b);
    awaddr_i = a; awlen_i = l; awsize_i = s; awburst_i = b;
    awvalid_i = 1; awready_i = 1;
    tick();
    awvalid_i = 0; awready_i = 0;
  endtask

  task automatic drive_r(input logic [63:0] d, input logic [127:0] xd,
                         input logic last);
    rdata_i = d; xrdata_i = xd; rlast_i = last;
    rvalid_i = 1; rready_i = 1;
    #1;
  endtask

  task automatic drive_w(input logic [31:0] d, input logic [3:0] s,
                         input logic last);
    wdata_i = d; wstrb_i = s; wlast_i = last;
    wvalid_i = 1; wready_i = 1;
    #1;
  endtask

  task automatic do_b();
    bvalid_i = 1; bready_i = 1;
    tick();
    bvalid_i = 0; bready_i = 0;
  endtask

  task automatic test_reset();
    arvalid_i = 1; arready_i = 1; awvalid_i = 1; awready_i = 1;
    wvalid_i = 1; wready_i = 1; wstrb_i = 4'hF;
    rdata_i = 64'hAAAA_BBBB_CCCC_DDDD;
    #1;
    n_tests++;
    if ({arvalid_o, arready_o, awvalid_o, awready_o} !== 4'hF) begin
      n_fail++;
      $display("FAIL rst_addr_gate: got %b want 1111",
               {arvalid_o, arready_o, awvalid_o, awready_o});
    end
    n_tests++;
    if ({wvalid_o, wready_o} !== 2'b00) begin
      n_fail++;
      $display("FAIL rst_w_gate: got %b want 00", {wvalid_o, wready_o});
    end
    n_tests++;
    if (wstrb_o !== 8'h0F) begin
      n_fail++;
      $display("FAIL rst_wstrb: got %h want 0f", wstrb_o);
    end
    n_tests++;
    if (rdata_o !== 32'hCCCC_DDDD) begin
      n_fail++;
      $display("FAIL rst_rdata: got %h want ccccdddd", rdata_o);
    end
    clear_inputs();
    tick();
    tick();
    rst = 0;
    #1;
  endtask

  task automatic test_read_incr();
    logic [63:0] d[4];
    logic [31:0] exp;
    for (int i = 0; i < 4; i++) begin
      d[i] = {$urandom, $urandom};
      rd_q.push_back((i % 2 == 0) ? d[i][63:32] : d[i][31:0]);
    end
    arid_i = 3; araddr_i = 32'h1004; arlen_i = 3; arsize_i = 2;
    arburst_i = 1; arvalid_i = 1; arready_i = 1;
    #1;
    n_tests++;
    if ({arvalid_o, arid_o, araddr_o, arlen_o, arsize_o, arburst_o} !==
        {1'b1, 4'd3, 32'h1004, 4'd3, 3'd2, 2'd1}) begin
      n_fail++;
      $display("FAIL ar_pass: got %b %h %h %h %h %h want 1 3 1004 3 2 1",
               arvalid_o, arid_o, araddr_o, arlen_o, arsize_o, arburst_o);
    end
    tick();
    arvalid_i = 0; arready_i = 0;
    rid_i = 3; rresp_i = 2'b01;
    for (int i = 0; i < 4; i++) begin
      drive_r(d[i], '0, i == 3);
      if (rvalid_o && rready_i) begin
        n_tests++;
        exp = (rd_q.size() != 0) ? rd_q.pop_front() : 32'hx;
        if (rdata_o !== exp) begin
          n_fail++;
          $display("FAIL rd_incr_beat%0d: got %h want %h", i, rdata_o, exp);
        end
      end
      if (i == 3) begin
        n_tests++;
        if ({rlast_o, rid_o, rresp_o} !== {1'b1, 4'd3, 2'b01}) begin
          n_fail++;
          $display("FAIL r_pass: got %b %h %b want 1 3 01",
                   rlast_o, rid_o, rresp_o);
        end
      end
      tick();
    end
    rvalid_i = 0; rlast_i = 0; rresp_i = 0; arready_i = 1;
    #1;
    n_tests++;
    if (arready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL rd_idle_after: got %b want 1", arready_o);
    end
    arready_i = 0;
    n_tests++;
    if (rd_q.size() != 0) begin
      n_fail++;
      $display("FAIL rd_incr_left: got %0d want 0", rd_q.size());
    end
    rd_q.delete();
  endtask

  task automatic test_read_block();
    logic [63:0] d[3];
    logic [31:0] exp;
    for (int i = 0; i < 3; i++) d[i] = {$urandom, $urandom};
    rd_q.push_back(d[0][31:0]);
    rd_q.push_back(d[1][63:32]);
    rd_q.push_back(d[2][31:0]);
    do_ar(32'h1000, 1, 2, 1);
    araddr_i = 32'h1100; arlen_i = 0; arvalid_i = 1; arready_i = 1;
    for (int i = 0; i < 3; i++) begin
      if (i == 0) #1;
      else drive_r(d[i-1], '0, i == 2);
      n_tests++;
      if ({arvalid_o, arready_o} !== 2'b00) begin
        n_fail++;
        $display("FAIL ar_block%0d: got %b want 00", i, {arvalid_o, arready_o});
      end
      if (i != 0 && rvalid_o && rready_i) begin
        n_tests++;
        exp = (rd_q.size() != 0) ? rd_q.pop_front() : 32'hx;
        if (rdata_o !== exp) begin
          n_fail++;
          $display("FAIL rd_blk_beat%0d: got %h want %h", i, rdata_o, exp);
        end
      end
      tick();
    end
    rvalid_i = 0; rlast_i = 0;
    #1;
    n_tests++;
    if ({arvalid_o, arready_o, araddr_o} !== {2'b11, 32'h1100}) begin
      n_fail++;
      $display("FAIL ar_reopen: got %b %h want 11 1100",
               {arvalid_o, arready_o}, araddr_o);
    end
    tick();
    arvalid_i = 0; arready_i = 0;
    drive_r(d[2], '0, 1);
    if (rvalid_o && rready_i) begin
      n_tests++;
      exp = (rd_q.size() != 0) ? rd_q.pop_front() : 32'hx;
      if (rdata_o !== exp) begin
        n_fail++;
        $display("FAIL rd_blk_second: got %h want %h", rdata_o, exp);
      end
    end
    tick();
    rvalid_i = 0; rlast_i = 0;
    n_tests++;
    if (rd_q.size() != 0) begin
      n_fail++;
      $display("FAIL rd_blk_left: got %0d want 0", rd_q.size());
    end
    rd_q.delete();
  endtask

  task automatic test_write_single();
    logic [31:0] wd;
    logic [71:0] exp;
    wd = $urandom;
    awid_i = 5; awaddr_i = 32'h2000; awlen_i = 0; awsize_i = 2;
    awburst_i = 1; awvalid_i = 1; awready_i = 1;
    #1;
    n_tests++;
    if ({awvalid_o, awid_o, awaddr_o, awsize_o} !==
        {1'b1, 4'd5, 32'h2000, 3'd2}) begin
      n_fail++;
      $display("FAIL aw_pass: got %b %h %h %h want 1 5 2000 2",
               awvalid_o, awid_o, awaddr_o, awsize_o);
    end
    tick();
    awvalid_i = 0; awready_i = 0;
    wid_i = 5;
    wq.push_back({8'h0F, wd, wd});
    drive_w(wd, 4'hF, 1);
    if (wvalid_o && wready_i) begin
      n_tests++;
      exp = (wq.size() != 0) ? wq.pop_front() : 72'hx;
      if ({wstrb_o, wdata_o} !== exp) begin
        n_fail++;
        $display("FAIL wr_single: got %h want %h", {wstrb_o, wdata_o}, exp);
      end
    end
    n_tests++;
    if ({wready_o, wlast_o, wid_o} !== {2'b11, 4'd5}) begin
      n_fail++;
      $display("FAIL w_pass: got %b %b %h want 1 1 5", wready_o, wlast_o, wid_o);
    end
    tick();
    wlast_i = 0; awready_i = 1;
    #1;
    n_tests++;
    if ({wvalid_o, wready_o, awready_o} !== 3'b000) begin
      n_fail++;
      $display("FAIL wr_resp_gate: got %b want 000",
               {wvalid_o, wready_o, awready_o});
    end
    wvalid_i = 0; wready_i = 0;
    bid_i = 5; bresp_i = 2'b10; bvalid_i = 1; bready_i = 1;
    #1;
    n_tests++;
    if ({bvalid_o, bready_o, bid_o, bresp_o} !== {2'b11, 4'd5, 2'b10}) begin
      n_fail++;
      $display("FAIL b_pass: got %b %b %h %b want 1 1 5 10",
               bvalid_o, bready_o, bid_o, bresp_o);
    end
    tick();
    bvalid_i = 0; bready_i = 0; bresp_i = 0;
    #1;
    n_tests++;
    if (awready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL wr_idle_after: got %b want 1", awready_o);
    end
    awready_i = 0;
    n_tests++;
    if (wq.size() != 0) begin
      n_fail++;
      $display("FAIL wr_single_left: got %0d want 0", wq.size());
    end
    wq.delete();
  endtask

  task automatic test_w_before_aw();
    logic [31:0] w[2];
    logic [71:0] exp;
    w[0] = $urandom; w[1] = $urandom;
    wdata_i = w[0]; wstrb_i = 4'hF; wlast_i = 0;
    wvalid_i = 1; wready_i = 1;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_tests++;
      if ({wvalid_o, wready_o} !== 2'b00) begin
        n_fail++;
        $display("FAIL w_early%0d: got %b want 00", c, {wvalid_o, wready_o});
      end
      tick();
    end
    awaddr_i = 32'h2000; awlen_i = 1; awsize_i = 2; awburst_i = 1;
    awvalid_i = 1; awready_i = 1;
    #1;
    n_tests++;
    if ({wvalid_o, wready_o} !== 2'b00) begin
      n_fail++;
      $display("FAIL w_early_aw: got %b want 00", {wvalid_o, wready_o});
    end
    tick();
    awvalid_i = 0; awready_i = 0;
    for (int i = 0; i < 2; i++) begin
      wq.push_back({(i == 0) ? 8'h0F : 8'hF0, w[i], w[i]});
      drive_w(w[i], 4'hF, i == 1);
      if (wvalid_o && wready_i) begin
        n_tests++;
        exp = (wq.size() != 0) ? wq.pop_front() : 72'hx;
        if ({wstrb_o, wdata_o} !== exp) begin
          n_fail++;
          $display("FAIL w_late_beat%0d: got %h want %h", i,
                   {wstrb_o, wdata_o}, exp);
        end
      end
      tick();
    end
    wvalid_i = 0; wready_i = 0; wlast_i = 0;
    do_b();
    n_tests++;
    if (wq.size() != 0) begin
      n_fail++;
      $display("FAIL w_late_left: got %0d want 0", wq.size());
    end
    wq.delete();
  endtask

  task automatic test_narrow_128();
    logic [127:0] xd[6];
    logic [31:0]  exp;
    logic [15:0]  sexp;
    for (int i = 0; i < 6; i++) begin
      xd[i] = {$urandom, $urandom, $urandom, $urandom};
      rd_q.push_back(xd[i][((3 + i) / 4) * 32 +: 32]);
    end
    do_ar(32'h3, 5, 0, 1);
    for (int i = 0; i < 6; i++) begin
      drive_r('0, xd[i], i == 5);
      if (x_rvalid_o && rready_i) begin
        n_tests++;
        exp = (rd_q.size() != 0) ? rd_q.pop_front() : 32'hx;
        if (x_rdata_o !== exp) begin
          n_fail++;
          $display("FAIL rd128_beat%0d: got %h want %h", i, x_rdata_o, exp);
        end
      end
      tick();
    end
    rvalid_i = 0; rlast_i = 0;
    do_aw(32'h3, 5, 0, 1);
    for (int i = 0; i < 6; i++) begin
      sexp = 16'(1) << (3 + i);
      xq.push_back(sexp);
      drive_w($urandom, 4'(1 << ((3 + i) % 4)), i == 5);
      if (x_wvalid_o && wready_i) begin
        n_tests++;
        sexp = (xq.size() != 0) ? xq.pop_front() : 16'hx;
        if (x_wstrb_o !== sexp) begin
          n_fail++;
          $display("FAIL wstrb128_beat%0d: got %h want %h", i, x_wstrb_o, sexp);
        end
      end
      tick();
    end
    wvalid_i = 0; wready_i = 0; wlast_i = 0;
    do_b();
    for (int i = 0; i < 3; i++) begin
      xd[i] = {$urandom, $urandom, $urandom, $urandom};
      rd_q.push_back(xd[i][63:32]);
    end
    do_ar(32'h6, 2, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drive_r('0, xd[i], i == 2);
      if (x_rvalid_o && rready_i) begin
        n_tests++;
        exp = (rd_q.size() != 0) ? rd_q.pop_front() : 32'hx;
        if (x_rdata_o !== exp) begin
          n_fail++;
          $display("FAIL rd128_fixed%0d: got %h want %h", i, x_rdata_o, exp);
        end
      end
      tick();
    end
    rvalid_i = 0; rlast_i = 0;
    n_tests++;
    if (rd_q.size() + xq.size() != 0) begin
      n_fail++;
      $display("FAIL n128_left: got %0d want 0", rd_q.size() + xq.size());
    end
    rd_q.delete();
    xq.delete();
  endtask

  task automatic test_reset_mid();
    logic [31:0] wd;
    logic [71:0] exp;
    do_ar(32'h1000, 3, 2, 1);
    do_aw(32'h2000, 3, 2, 1);
    drive_w($urandom, 4'hF, 0);
    tick();
    #1;
    n_tests++;
    if (wstrb_o !== 8'hF0) begin
      n_fail++;
      $display("FAIL pre_rst_ptr: got %h want f0", wstrb_o);
    end
    rst = 1; arready_i = 1; awready_i = 1;
    #1;
    n_tests++;
    if (wstrb_o !== 8'h0F) begin
      n_fail++;
      $display("FAIL rst_mid_ptr: got %h want 0f", wstrb_o);
    end
    n_tests++;
    if ({wvalid_o, wready_o, arready_o, awready_o} !== 4'b0011) begin
      n_fail++;
      $display("FAIL rst_mid_idle: got %b want 0011",
               {wvalid_o, wready_o, arready_o, awready_o});
    end
    clear_inputs();
    #2;
    rst = 0;
    tick();
    do_aw(32'h2004, 0, 2, 1);
    wd = $urandom;
    wq.push_back({8'hF0, wd, wd});
    drive_w(wd, 4'hF, 1);
    n_tests++;
    if (wvalid_o && wready_i) begin
      exp = (wq.size() != 0) ? wq.pop_front() : 72'hx;
      if ({wstrb_o, wdata_o} !== exp) begin
        n_fail++;
        $display("FAIL rst_fresh_w: got %h want %h", {wstrb_o, wdata_o}, exp);
      end
    end else begin
      n_fail++;
      $display("FAIL rst_fresh_w: got wvalid_o=%b want 1", wvalid_o);
    end
    tick();
    wvalid_i = 0; wready_i = 0; wlast_i = 0;
    do_b();
    awready_i = 1;
    #1;
    n_tests++;
    if (awready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_fresh_idle: got %b want 1", awready_o);
    end
    awready_i = 0;
    wq.delete();
  endtask

  initial begin
    rst = 1;
    arid_i = 0; araddr_i = 0; arlen_i = 0; arsize_i = 0; arburst_i = 0;
    awid_i = 0; awaddr_i = 0; awlen_i = 0; awsize_i = 0; awburst_i = 0;
    wid_i = 0; rid_i = 0; bid_i = 0; rresp_i = 0; bresp_i = 0;
    rdata_i = 0; xrdata_i = 0; wdata_i = 0; wstrb_i = 0;
    clear_inputs();
    test_reset();
    test_read_incr();
    test_read_block();
    test_write_single();
    test_w_before_aw();
    test_narrow_128();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

endmodule
